// File: rtl/op_sequencer.sv
// Instruction sequencer for the 4-bit processor: gathers opcode/A/B from push strobes,
// then steps the register file and ALU and latches the result and flags for the LCD.
module op_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] no,
  input  logic       push,
  output logic [3:0] rf_rr1,
  output logic [3:0] rf_rr2,
  output logic [3:0] rf_wr,
  output logic [3:0] rf_wdata,
  output logic       rf_we,
  input  logic [3:0] rf_rdata1,
  input  logic [3:0] rf_rdata2,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_res,
  input  logic       alu_cf,
  input  logic       alu_zf,
  input  logic       alu_sf,
  output logic [3:0] res,
  output logic       cf,
  output logic       zf,
  output logic       sf,
  output logic       invalid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, READ, EXEC, WRITE, DONE} state_t;

  localparam logic [2:0] OP_WRITE = 3'd4;

  state_t     state;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       we_q;
  logic       op_ok;

  assign op_ok = !no[3] && (no[2:0] <= OP_WRITE);

  // Reset gates the strobe combinationally so an interrupted WRITE never commits.
  assign rf_we = we_q & ~rst;

  // Read data is registered by the register file, so it is only meaningful in EXEC.
  assign alu_a = (state == EXEC) ? rf_rdata1 : 4'd0;
  assign alu_b = (state == EXEC) ? rf_rdata2 : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      a        <= '0;
      b        <= '0;
      we_q     <= 1'b0;
      rf_rr1   <= '0;
      rf_rr2   <= '0;
      rf_wr    <= '0;
      rf_wdata <= '0;
      alu_sel  <= '0;
      res      <= '0;
      cf       <= 1'b0;
      zf       <= 1'b0;
      sf       <= 1'b0;
      invalid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      we_q     <= 1'b0;
      rf_rr1   <= '0;
      rf_rr2   <= '0;
      rf_wr    <= '0;
      rf_wdata <= '0;
      alu_sel  <= '0;
      done     <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (push) begin
            if (op_ok) begin
              op      <= no[2:0];
              invalid <= 1'b0;
              busy    <= 1'b1;
              state   <= GET_A;
            end else begin
              invalid <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        GET_A: begin
          if (push) begin
            a     <= no;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (push) begin
            b <= no;
            if (op == OP_WRITE) begin
              we_q     <= 1'b1;
              rf_wr    <= a;
              rf_wdata <= no;
              state    <= WRITE;
            end else begin
              rf_rr1 <= a;
              rf_rr2 <= no;
              state  <= READ;
            end
          end
        end
        READ: begin
          // and/or/add/sub (0..3) map onto ALU selects 10/11/00/01.
          alu_sel <= {~op[1], op[0]};
          state   <= EXEC;
        end
        EXEC: begin
          res   <= alu_res;
          cf    <= alu_cf;
          zf    <= alu_zf;
          sf    <= alu_sf;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        WRITE: begin
          res   <= b;
          cf    <= 1'b0;
          zf    <= (b == 4'd0);
          sf    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: register file and ALU models around the DUT, a table of
// instructions with fixed expectations, hand sequences and a randomized instruction stream.
module tb_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] no;
  logic       push;
  logic [3:0] rf_rr1, rf_rr2, rf_wr, rf_wdata, rf_rdata1, rf_rdata2;
  logic       rf_we;
  logic [3:0] alu_a, alu_b, alu_res, res;
  logic [1:0] alu_sel;
  logic       alu_cf, alu_zf, alu_sf, cf, zf, sf, invalid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] mem     [16];
  logic [3:0] ref_mem [16];
  logic [6:0] last;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  op_sequencer dut (
    .clk(clk), .rst(rst), .no(no), .push(push),
    .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_wr(rf_wr), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_sf(alu_sf),
    .res(res), .cf(cf), .zf(zf), .sf(sf),
    .invalid(invalid), .busy(busy), .done(done)
  );

  // Register file: registered read, write on the clock edge.
  always @(posedge clk) begin
    if (rf_we) mem[rf_wr] <= rf_wdata;
    rf_rdata1 <= mem[rf_rr1];
    rf_rdata2 <= mem[rf_rr2];
  end

  // Returns {cf, zf, sf, res}; sub carries out a borrow.
  function automatic logic [6:0] alu_fn(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] t;
    case (s)
      2'b00:   t = {1'b0, x} + {1'b0, y};
      2'b01:   t = {1'b0, x} - {1'b0, y};
      2'b10:   t = {1'b0, x & y};
      default: t = {1'b0, x | y};
    endcase
    return {t[4], t[3:0] == 4'd0, t[3], t[3:0]};
  endfunction

  assign {alu_cf, alu_zf, alu_sf, alu_res} = alu_fn(alu_sel, alu_a, alu_b);

  function automatic logic [1:0] exp_sel(input logic [3:0] op);
    case (op)
      4'd0:    return 2'b10;
      4'd1:    return 2'b11;
      4'd2:    return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [6:0] model_exp(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    if (op == 4'd4) return {1'b0, b == 4'd0, 1'b0, b};
    if (op > 4'd4) return last;
    return alu_fn(exp_sel(op), ref_mem[a], ref_mem[b]);
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_nib(input logic [3:0] v);
    no   = v;
    push = 1'b1;
    @(negedge clk);
    push = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the first DONE cycle (or after the rejected opcode).
  task automatic do_instr(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input int gap, input bit spur, input logic [6:0] exp);
    if (gap > 0) begin
      @(negedge clk);
      chk("done_one_cycle", 40'(done), 40'd0);
      repeat (gap - 1) @(negedge clk);
    end
    push_nib(op);
    if (op > 4'd4) begin
      chk("invalid_set", 40'(invalid), 40'd1);
      chk("invalid_idle", 40'({busy, done}), 40'd0);
      chk("invalid_keep", 40'({cf, zf, sf, res}), 40'(last));
      return;
    end
    chk("accept", 40'({busy, invalid}), 40'b10);
    repeat (gap) @(negedge clk);
    push_nib(a);
    repeat (gap) @(negedge clk);
    push_nib(b);
    push = spur;
    if (op == 4'd4) begin
      chk("write_port", 40'({rf_we, rf_wr, rf_wdata}), 40'({1'b1, a, b}));
      @(negedge clk);
      push = 1'b0;
    end else begin
      chk("read_port", 40'({rf_we, rf_rr1, rf_rr2, busy}), 40'({1'b0, a, b, 1'b1}));
      @(negedge clk);
      chk("exec_alu", 40'({alu_a, alu_b, alu_sel, done}),
          40'({ref_mem[a], ref_mem[b], exp_sel(op), 1'b0}));
      @(negedge clk);
      push = 1'b0;
    end
    chk("done_state", 40'({done, busy, rf_we}), 40'b100);
    chk("result", 40'({cf, zf, sf, res}), 40'(exp));
    if (op == 4'd4) ref_mem[a] = b;
    last = exp;
  endtask

  function automatic logic [39:0] all_outs();
    return 40'({rf_rr1, rf_rr2, rf_wr, rf_wdata, rf_we, alu_a, alu_b, alu_sel,
                res, cf, zf, sf, invalid, busy, done});
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op, a, b;
    tbl[0]  = '{4'h4, 4'h3, 4'hA, 7'h0A};
    tbl[1]  = '{4'h4, 4'h5, 4'h7, 7'h07};
    tbl[2]  = '{4'h4, 4'h1, 4'h0, 7'h20};
    tbl[3]  = '{4'h4, 4'h2, 4'hF, 7'h0F};
    tbl[4]  = '{4'h2, 4'h3, 4'h5, 7'h41};
    tbl[5]  = '{4'h3, 4'h5, 4'h3, 7'h5D};
    tbl[6]  = '{4'h3, 4'h3, 4'h3, 7'h20};
    tbl[7]  = '{4'h0, 4'h2, 4'h3, 7'h1A};
    tbl[8]  = '{4'h1, 4'h1, 4'h5, 7'h07};
    tbl[9]  = '{4'h0, 4'h1, 4'h2, 7'h20};
    tbl[10] = '{4'h2, 4'h2, 4'h2, 7'h5E};
    tbl[11] = '{4'h3, 4'h3, 4'h5, 7'h03};

    for (int i = 0; i < 16; i++) ref_mem[i] = 4'd0;
    last = 7'd0;
    rst  = 1'b1;
    push = 1'b0;
    no   = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 40'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      do_instr(tbl[i].op, tbl[i].a, tbl[i].b, i % 3, (i % 2) == 1, tbl[i].exp);

    // Rejected opcodes, then a valid one clears the flag.
    do_instr(4'h7, 4'h0, 4'h0, 1, 1'b0, last);
    do_instr(4'h8, 4'h0, 4'h0, 0, 1'b0, last);
    do_instr(4'h0, 4'h3, 4'h2, 1, 1'b0, model_exp(4'h0, 4'h3, 4'h2));

    // Opcode pushed in the done cycle itself.
    do_instr(4'h4, 4'h6, 4'h9, 1, 1'b0, model_exp(4'h4, 4'h6, 4'h9));
    do_instr(4'h2, 4'h6, 4'h5, 0, 1'b1, model_exp(4'h2, 4'h6, 4'h5));
    do_instr(4'h3, 4'h6, 4'h3, 0, 1'b0, model_exp(4'h3, 4'h6, 4'h3));

    // Reset during the WRITE cycle must not commit the write.
    @(negedge clk);
    push_nib(4'h4);
    push_nib(4'h5);
    push_nib(4'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", all_outs(), 40'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_write", 40'(mem[5]), 40'(ref_mem[5]));
    last = 7'd0;

    for (int i = 0; i < 16; i++) begin
      b = 4'($urandom_range(0, 15));
      do_instr(4'h4, 4'(i), b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               model_exp(4'h4, 4'(i), b));
    end

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      do_instr(op, a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), model_exp(op, a, b));
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) chk("final_regfile", 40'(mem[i]), 40'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
